led_pattern_ctrl: RTL and testbench

User-project GPIO block for the Caravel harness. It samples three push-buttons on mprj_io[9:7], synchronises and optionally debounces them, and decodes the 3-bit value into one of eight LED display modes. The selected pattern drives eight LEDs on mprj_io[17:10]. It sits inside the user project wrapper, clocked by the Wishbone clock, with no bus slave of its own.

---
 rtl/led_pattern_ctrl_if.sv | 23 ++
 rtl/led_pattern_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if
// Pad-side bundle of the Caravel user GPIO block: the 38 pad inputs,
// the 38 pad outputs and their active-low output enables.
// The block consumes the bundle through the slave modport; whatever
// drives the pads (wrapper or bench) uses the master modport.

interface led_pattern_ctrl_if;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    modport slave (
        input  io_in,
        output io_out,
        output io_oeb
    );

    modport master (
        output io_in,
        input  io_out,
        input  io_oeb
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
// Samples three push-buttons on io_in[9:7], synchronises and optionally
// debounces them, and shows one of eight LED patterns on io_out[17:10].
// Optional feature macro: LED_DEBOUNCE_EN (defined = debouncer compiled in;
// undefined = the second synchroniser flop is used directly as the mode).
//
// Bounce direction FSM:
//   state    | meaning
//   DIR_UP   | bounce position moving 0 -> 7
//   DIR_DOWN | bounce position moving 7 -> 0

module led_pattern_ctrl #(
    parameter int TICK_CYCLES     = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    led_pattern_ctrl_if.slave io
);

    localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        MODE_OFF    = 3'b000,
        MODE_COUNT  = 3'b001,
        MODE_ROT_L  = 3'b010,
        MODE_ROT_R  = 3'b011,
        MODE_BOUNCE = 3'b100,
        MODE_ALT    = 3'b101,
        MODE_HALVES = 3'b110,
        MODE_ON     = 3'b111
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    mode_t         mode;
    logic [2:0]    mode_prev;
    logic          mode_change;
    logic          tick;

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_next;
    logic [7:0]    led_q;
    logic [7:0]    led_next;
    logic [2:0]    pos_q;
    logic [2:0]    pos_next;
    dir_t          dir_q;
    dir_t          dir_next;

    logic          unused_io;
    assign unused_io = ^{io.io_in[37:10], io.io_in[6:0]};

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= io.io_in[9:7];
            sync2 <= sync1;
        end
    end

`ifdef LED_DEBOUNCE_EN
    // db_cnt holds (consecutive stable cycles - 1), saturating at DEBOUNCE_CYCLES-1
    localparam int            DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]    cand;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] run;
    logic [2:0]    mode_q;

    // Length of the current stable run including this cycle (minus one)
    always_comb begin
        run = '0;
        if (sync2 == cand) begin
            if (db_cnt == DB_LAST) begin
                run = DB_LAST;
            end else begin
                run = db_cnt + DW'(1);
            end
        end
    end

    // Candidate tracking and acceptance of a value stable long enough
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cand   <= 3'b000;
            db_cnt <= '0;
            mode_q <= 3'b000;
        end else begin
            cand   <= sync2;
            db_cnt <= run;
            if (run == DB_LAST) begin
                mode_q <= sync2;
            end
        end
    end

    assign mode = mode_t'(mode_q);
`else
    logic unused_db;
    assign unused_db = (DEBOUNCE_CYCLES > 0);

    // Without debounce the last synchroniser stage is the mode register,
    // which keeps the button-to-LED path at three cycles.
    assign mode = mode_t'(sync2);
`endif

    assign mode_change = (mode != mode_prev);
    assign tick        = (presc_q == TICK_LAST);

    // State registers: previous mode, prescaler, pattern, bounce FSM
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mode_prev <= 3'b000;
            presc_q   <= '0;
            led_q     <= 8'h00;
            pos_q     <= 3'd0;
            dir_q     <= DIR_UP;
        end else begin
            mode_prev <= mode;
            presc_q   <= presc_next;
            led_q     <= led_next;
            pos_q     <= pos_next;
            dir_q     <= dir_next;
        end
    end

    // Next pattern state: start value on mode entry, otherwise step on tick
    always_comb begin
        presc_next = presc_q;
        led_next   = led_q;
        pos_next   = pos_q;
        dir_next   = dir_q;

        if (mode_change) begin
            presc_next = '0;
            pos_next   = 3'd0;
            dir_next   = DIR_UP;
            case (mode)
                MODE_OFF:    led_next = 8'h00;
                MODE_COUNT:  led_next = 8'h00;
                MODE_ROT_L:  led_next = 8'h01;
                MODE_ROT_R:  led_next = 8'h80;
                MODE_BOUNCE: led_next = 8'h01;
                MODE_ALT:    led_next = 8'h55;
                MODE_HALVES: led_next = 8'h0F;
                MODE_ON:     led_next = 8'hFF;
                default:     led_next = 8'h00;
            endcase
        end else begin
            presc_next = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                case (mode)
                    MODE_OFF:    led_next = 8'h00;
                    MODE_COUNT:  led_next = led_q + 8'd1;
                    MODE_ROT_L:  led_next = {led_q[6:0], led_q[7]};
                    MODE_ROT_R:  led_next = {led_q[0], led_q[7:1]};
                    MODE_BOUNCE: begin
                        case (dir_q)
                            DIR_UP: begin
                                if (pos_q == 3'd7) begin
                                    pos_next = 3'd6;
                                    dir_next = DIR_DOWN;
                                end else begin
                                    pos_next = pos_q + 3'd1;
                                end
                            end
                            DIR_DOWN: begin
                                if (pos_q == 3'd0) begin
                                    pos_next = 3'd1;
                                    dir_next = DIR_UP;
                                end else begin
                                    pos_next = pos_q - 3'd1;
                                end
                            end
                            default: begin
                                pos_next = 3'd0;
                                dir_next = DIR_UP;
                            end
                        endcase
                        led_next = 8'h01 << pos_next;
                    end
                    MODE_ALT:    led_next = ~led_q;
                    MODE_HALVES: led_next = ~led_q;
                    MODE_ON:     led_next = 8'hFF;
                    default:     led_next = 8'h00;
                endcase
            end
        end
    end

    assign io.io_out = {20'h00000, led_q, 10'h000};
    assign io.io_oeb = {20'hFFFFF, 8'h00, 10'h3FF};

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl
// Directed bench: u_slow runs with TICK_CYCLES=4, u_fast with TICK_CYCLES=1.
// Expected latencies depend on whether LED_DEBOUNCE_EN is defined.

module tb_led_pattern_ctrl;

`ifdef LED_DEBOUNCE_EN
    localparam int LAT = 19;
    localparam bit DB  = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DB  = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    led_pattern_ctrl_if ifa ();
    led_pattern_ctrl_if ifb ();

    led_pattern_ctrl #(.TICK_CYCLES(4), .DEBOUNCE_CYCLES(16)) u_slow (
        .wb_clk_i (clk),
        .wb_rst_i (rst_a),
        .io       (ifa)
    );

    led_pattern_ctrl #(.TICK_CYCLES(1), .DEBOUNCE_CYCLES(16)) u_fast (
        .wb_clk_i (clk),
        .wb_rst_i (rst_b),
        .io       (ifb)
    );

    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] pat(input logic [7:0] v);
        return {20'h00000, v, 10'h000};
    endfunction

    logic [7:0] bounce_tbl [16];
    logic [7:0] exp_g;

    initial begin
        bounce_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        ifa.io_in = '0;
        ifb.io_in = '0;

        // reset
        wait_n(3);
        chk("rst_out_a", ifa.io_out, pat(8'h00));
        chk("rst_oeb_a", ifa.io_oeb, {20'hFFFFF, 8'h00, 10'h3FF});
        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_n(2);
        chk("post_rst_out_a", ifa.io_out, pat(8'h00));
        chk("post_rst_oeb_b", ifb.io_oeb, {20'hFFFFF, 8'h00, 10'h3FF});

        // 111: constant on, exact latency
        ifa.io_in[9:7] = 3'b111;
        wait_n(LAT - 1);
        chk("on_before", ifa.io_out, pat(8'h00));
        wait_n(1);
        chk("on_at_lat", ifa.io_out, pat(8'hFF));
        wait_n(20);
        chk("on_hold", ifa.io_out, pat(8'hFF));

        // back to 000
        ifa.io_in[9:7] = 3'b000;
        wait_n(LAT);
        chk("off", ifa.io_out, pat(8'h00));

        // 001: counter, one step per 4 cycles, wraps after 256 steps
        ifa.io_in[9:7] = 3'b001;
        wait_n(LAT);
        chk("cnt_start", ifa.io_out, pat(8'h00));
        wait_n(3);
        chk("cnt_pre_step", ifa.io_out, pat(8'h00));
        wait_n(1);
        chk("cnt_step1", ifa.io_out, pat(8'h01));
        for (int i = 2; i <= 256; i++) begin
            wait_n(4);
            exp_g = 8'(i);
            chk($sformatf("cnt_step%0d", i), ifa.io_out, pat(exp_g));
        end

        // glitch: 5-cycle pulse of 111 from 000
        ifa.io_in[9:7] = 3'b000;
        wait_n(LAT + 2);
        chk("glitch_base", ifa.io_out, pat(8'h00));
        ifa.io_in[9:7] = 3'b111;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (!DB && k >= 3 && k <= 7) exp_g = 8'hFF;
            else                         exp_g = 8'h00;
            chk($sformatf("glitch_k%0d", k), ifa.io_out, pat(exp_g));
            if (k == 5) ifa.io_in[9:7] = 3'b000;
        end

        // 101: alternate
        ifa.io_in[9:7] = 3'b101;
        wait_n(LAT);
        chk("alt_start", ifa.io_out, pat(8'h55));
        wait_n(3);
        chk("alt_pre", ifa.io_out, pat(8'h55));
        wait_n(1);
        chk("alt_step1", ifa.io_out, pat(8'hAA));
        wait_n(4);
        chk("alt_step2", ifa.io_out, pat(8'h55));

        // 110: halves
        ifa.io_in[9:7] = 3'b110;
        wait_n(LAT);
        chk("half_start", ifa.io_out, pat(8'h0F));
        wait_n(4);
        chk("half_step1", ifa.io_out, pat(8'hF0));

        // 011: rotate right
        ifa.io_in[9:7] = 3'b011;
        wait_n(LAT);
        chk("rotr_start", ifa.io_out, pat(8'h80));
        wait_n(4);
        chk("rotr_step1", ifa.io_out, pat(8'h40));

        // 010: rotate left, then a one-cycle reset mid-pattern
        ifa.io_in[9:7] = 3'b010;
        wait_n(LAT);
        chk("rotl_start", ifa.io_out, pat(8'h01));
        wait_n(4);
        chk("rotl_step1", ifa.io_out, pat(8'h02));
        wait_n(4);
        chk("rotl_step2", ifa.io_out, pat(8'h04));
        rst_a = 1'b1;
        wait_n(1);
        chk("rotl_rst", ifa.io_out, pat(8'h00));
        rst_a = 1'b0;
        wait_n(LAT - 1);
        chk("rotl_reacq_pre", ifa.io_out, pat(8'h00));
        wait_n(1);
        chk("rotl_reacq", ifa.io_out, pat(8'h01));
        wait_n(4);
        chk("rotl_reacq_step", ifa.io_out, pat(8'h02));

        // fast instance: 100 bounce, a step every cycle
        ifb.io_in[9:7] = 3'b100;
        wait_n(LAT);
        chk("bounce_start", ifb.io_out, pat(8'h01));
        for (int j = 0; j < 16; j++) begin
            wait_n(1);
            chk($sformatf("bounce_%0d", j), ifb.io_out, pat(bounce_tbl[j]));
        end

        // fast instance: 001 counter at one step per cycle
        ifb.io_in[9:7] = 3'b001;
        wait_n(LAT);
        chk("fcnt_start", ifb.io_out, pat(8'h00));
        wait_n(1);
        chk("fcnt_1", ifb.io_out, pat(8'h01));
        wait_n(1);
        chk("fcnt_2", ifb.io_out, pat(8'h02));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
